// File: rtl/param_sync_memory.sv
// Parametrised synchronous memory: separate read/write ports, byte enables,
// read latency 1 or 2, selectable read-during-write, and a hardware clear sweep.
//
// state | meaning
// CLEAR | sweeping zeros into mem[cnt]; accesses ignored, busy high
// IDLE  | normal read/write service; clr starts a new sweep
module param_sync_memory #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 6,
  parameter int READ_LAT = 1,
  parameter int RDW_MODE = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  output logic                  busy,
  input  logic                  ren,
  input  logic [ADDR_W-1:0]     raddr,
  input  logic                  wen,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [DATA_W-1:0]     din,
  output logic [DATA_W-1:0]     dout,
  output logic                  dvalid
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = '1;

  if (DATA_W % 8 != 0) begin : g_bad_width
    $error("param_sync_memory: DATA_W must be a multiple of 8");
  end
  if (READ_LAT != 1 && READ_LAT != 2) begin : g_bad_lat
    $error("param_sync_memory: READ_LAT must be 1 or 2");
  end

  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   cnt, cnt_nxt;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DATA_W-1:0]   old_word, merged, rd_word;
  logic [DATA_W-1:0]   s1_data;
  logic                s1_valid;
  logic                rd_en, wr_en;

  assign busy  = (state == ST_CLEAR);
  assign rd_en = !ren && !busy;
  assign wr_en = !wen && !busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_CLEAR: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == LAST) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end
      end
      ST_IDLE: begin
        if (clr) begin
          state_nxt = ST_CLEAR;
          cnt_nxt   = '0;
        end
      end
      default: state_nxt = ST_CLEAR;
    endcase
  end

  // Storage has no reset; the sweep is what zeroes it.
  always_ff @(posedge clk) begin
    if (busy) begin
      mem[cnt] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) mem[waddr][8*i +: 8] <= din[8*i +: 8];
      end
    end
  end

  always_comb begin
    old_word = mem[raddr];
    merged   = mem[waddr];
    for (int i = 0; i < NB; i++) begin
      if (be[i]) merged[8*i +: 8] = din[8*i +: 8];
    end
    rd_word = old_word;
    if (RDW_MODE == 1 && wr_en && (waddr == raddr)) rd_word = merged;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_data  <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_data  <= rd_en ? rd_word : '0;
      s1_valid <= rd_en;
    end
  end

  if (READ_LAT == 2) begin : g_lat2
    logic [DATA_W-1:0] s2_data;
    logic              s2_valid;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s2_data  <= '0;
        s2_valid <= 1'b0;
      end else begin
        s2_data  <= s1_data;
        s2_valid <= s1_valid;
      end
    end
    assign dout   = s2_data;
    assign dvalid = s2_valid;
  end else begin : g_lat1
    assign dout   = s1_data;
    assign dvalid = s1_valid;
  end

endmodule

// File: tb/tb_param_sync_memory.sv
// Bench for param_sync_memory: three configurations share one stimulus stream
// (lat1/old-data, lat1/new-data, lat2/old-data) against a reference memory model.
module tb_param_sync_memory;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        clr = 1'b0;
  logic        ren = 1'b1;
  logic        wen = 1'b1;
  logic [5:0]  raddr = '0;
  logic [5:0]  waddr = '0;
  logic [1:0]  be = '0;
  logic [15:0] din = '0;
  logic        busy_a, busy_b, busy_c;
  logic [15:0] dout_a, dout_b, dout_c;
  logic        dvalid_a, dvalid_b, dvalid_c;

  always #5 clk = ~clk;

  param_sync_memory #(.DATA_W(16), .ADDR_W(6), .READ_LAT(1), .RDW_MODE(0)) u_a (
    .clk(clk), .rst_n(rst_n), .clr(clr), .busy(busy_a), .ren(ren), .raddr(raddr),
    .wen(wen), .waddr(waddr), .be(be), .din(din), .dout(dout_a), .dvalid(dvalid_a));
  param_sync_memory #(.DATA_W(16), .ADDR_W(6), .READ_LAT(1), .RDW_MODE(1)) u_b (
    .clk(clk), .rst_n(rst_n), .clr(clr), .busy(busy_b), .ren(ren), .raddr(raddr),
    .wen(wen), .waddr(waddr), .be(be), .din(din), .dout(dout_b), .dvalid(dvalid_b));
  param_sync_memory #(.DATA_W(16), .ADDR_W(6), .READ_LAT(2), .RDW_MODE(0)) u_c (
    .clk(clk), .rst_n(rst_n), .clr(clr), .busy(busy_c), .ren(ren), .raddr(raddr),
    .wen(wen), .waddr(waddr), .be(be), .din(din), .dout(dout_c), .dvalid(dvalid_c));

  typedef struct {logic v; logic [15:0] d;} exp_t;

  exp_t        qa[$], qb[$], qc[$];
  logic [15:0] mem_m [64];
  logic        busy_m;
  int          cnt_m;
  int          passed = 0;
  int          total = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d,
                                        input logic [1:0] b);
    logic [15:0] r;
    r = old;
    if (b[0]) r[7:0]  = d[7:0];
    if (b[1]) r[15:8] = d[15:8];
    return r;
  endfunction

  // Model one clock edge with the inputs currently driven, then check all DUTs.
  task automatic step();
    exp_t ea, eb, e;
    logic [15:0] old, mrg;
    ea = '{v: 1'b0, d: 16'h0};
    eb = ea;
    if (busy_m) begin
      mem_m[cnt_m] = 16'h0;
    end else begin
      old = mem_m[raddr];
      mrg = merge(mem_m[waddr], din, be);
      if (!ren) begin
        ea = '{v: 1'b1, d: old};
        eb = '{v: 1'b1, d: (!wen && waddr == raddr) ? mrg : old};
      end
      if (!wen) mem_m[waddr] = mrg;
    end
    qa.push_back(ea);
    qb.push_back(eb);
    qc.push_back(ea);
    if (busy_m) begin
      cnt_m++;
      if (cnt_m == 64) busy_m = 1'b0;
    end else if (clr) begin
      busy_m = 1'b1;
      cnt_m  = 0;
    end
    @(posedge clk);
    #1;
    e = qa.pop_front();
    chk("a_dvalid", {15'h0, dvalid_a}, {15'h0, e.v});
    chk("a_dout", dout_a, e.d);
    e = qb.pop_front();
    chk("b_dvalid", {15'h0, dvalid_b}, {15'h0, e.v});
    chk("b_dout", dout_b, e.d);
    e = qc.pop_front();
    chk("c_dvalid", {15'h0, dvalid_c}, {15'h0, e.v});
    chk("c_dout", dout_c, e.d);
    chk("busy_a", {15'h0, busy_a}, {15'h0, busy_m});
    chk("busy_c", {15'h0, busy_c}, {15'h0, busy_m});
  endtask

  task automatic set_idle();
    ren = 1'b1; wen = 1'b1; clr = 1'b0; be = 2'b00; din = 16'h0;
  endtask

  task automatic idle(input int n);
    set_idle();
    repeat (n) step();
  endtask

  task automatic wr(input logic [5:0] a, input logic [15:0] d, input logic [1:0] b);
    set_idle();
    wen = 1'b0; waddr = a; din = d; be = b;
    step();
  endtask

  task automatic rd(input logic [5:0] a);
    set_idle();
    ren = 1'b0; raddr = a;
    step();
  endtask

  // Asserts reset at the current time and checks the outputs clear without an edge.
  task automatic do_reset();
    set_idle();
    rst_n = 1'b0;
    #1;
    chk("rst_dout_a", dout_a, 16'h0);
    chk("rst_dout_c", dout_c, 16'h0);
    chk("rst_dvalid_a", {15'h0, dvalid_a}, 16'h0);
    chk("rst_dvalid_b", {15'h0, dvalid_b}, 16'h0);
    chk("rst_dvalid_c", {15'h0, dvalid_c}, 16'h0);
    chk("rst_busy", {15'h0, busy_a}, 16'h1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    qa.delete(); qb.delete(); qc.delete();
    qc.push_back('{v: 1'b0, d: 16'h0});
    busy_m = 1'b1;
    cnt_m  = 0;
  endtask

  task automatic wait_sweep();
    int guard;
    guard = 0;
    set_idle();
    ren = 1'b0; raddr = 6'd10;
    while (busy_m && guard < 100) begin
      step();
      guard++;
    end
    total++;
    assert (!busy_m) passed++;
    else $error("FAIL sweep_timeout observed=%0d expected=<100", guard);
  endtask

  initial begin
    #2;
    do_reset();
    wait_sweep();

    rd(6'h3F);
    idle(1);

    wr(6'd5, 16'hABCD, 2'b11);
    wr(6'd5, 16'h1234, 2'b01);
    rd(6'd5);
    idle(1);

    wr(6'd7, 16'h00FF, 2'b11);
    set_idle();
    ren = 1'b0; raddr = 6'd7; wen = 1'b0; waddr = 6'd7; din = 16'h5500; be = 2'b11;
    step();
    rd(6'd7);
    set_idle();
    ren = 1'b0; raddr = 6'd5; wen = 1'b0; waddr = 6'd20; din = 16'h7777; be = 2'b10;
    step();
    rd(6'd20);
    wr(6'd20, 16'h0000, 2'b00);
    rd(6'd20);
    idle(1);

    wr(6'd1, 16'h0001, 2'b11);
    wr(6'd2, 16'h0002, 2'b11);
    wr(6'd3, 16'h0003, 2'b11);
    rd(6'd1);
    rd(6'd2);
    rd(6'd3);
    idle(2);

    wr(6'd10, 16'hFFFF, 2'b11);
    set_idle();
    ren = 1'b0; raddr = 6'd10; clr = 1'b1;
    step();
    wait_sweep();
    rd(6'd10);
    idle(2);

    wr(6'd40, 16'hBEEF, 2'b11);
    rd(6'd40);
    #3;
    do_reset();
    idle(30);
    #3;
    do_reset();
    wait_sweep();
    rd(6'd40);
    idle(2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
